// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem read port, decoder valid/ready handshake and redirect for the fetch stage
interface instr_fetch_if #(parameter int ADDR_W = 10);
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halted;
  modport master (
    output imem_en, imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_rdata, instr_ready, redirect, redirect_pc
  );
  modport slave (
    input  imem_en, imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC, sync-read imem requests, 2-entry output buffer, redirect flush.
// Define FETCH_HALT_DETECT_EN to stop fetching after the 32'hFFFF_FFFF halt word.
module instr_fetch #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d, cp;
  logic [31:0]       dat_q [2], dat_d [2];
  logic [ADDR_W-1:0] bpc_q [2], bpc_d [2];
  logic              pop, push, req;
  // Entry 0 is always the head; a pop shifts entry 1 down before the push lands at cp.
  always_comb begin
    pop        = count_q != 2'd0 && bus.instr_ready;
    cp         = count_q - {1'b0, pop};
    req        = !rst && state_q == RUN && !bus.redirect && (cp + {1'b0, inflight_q}) < 2'd2;
    push       = inflight_q && !bus.redirect && state_q == RUN;
    state_d    = state_q;
    pc_d       = req ? pc_q + 1'b1 : pc_q;
    ipc_d      = req ? pc_q : ipc_q;
    inflight_d = req;
    count_d    = cp + {1'b0, push};
    dat_d      = dat_q;
    bpc_d      = bpc_q;
    if (pop) begin
      dat_d[0] = dat_q[1];
      bpc_d[0] = bpc_q[1];
    end
    if (push) begin
      dat_d[cp[0]] = bus.imem_rdata;
      bpc_d[cp[0]] = ipc_q;
    end
`ifdef FETCH_HALT_DETECT_EN
    state_d = (push && bus.imem_rdata == 32'hFFFF_FFFF) ? DRAIN : state_d;
    state_d = (state_q == DRAIN && pop && dat_q[0] == 32'hFFFF_FFFF) ? HALTED : state_d;
`endif
    if (bus.redirect && state_q != HALTED) begin
      state_d    = RUN;
      pc_d       = bus.redirect_pc;
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      ipc_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      dat_q      <= '{default: '0};
      bpc_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ipc_q      <= ipc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      dat_q      <= dat_d;
      bpc_q      <= bpc_d;
    end
  end
  assign bus.imem_en     = req;
  assign bus.imem_addr   = req ? pc_q : '0;
  assign bus.instr       = dat_q[0];
  assign bus.instr_pc    = bpc_q[0];
  assign bus.instr_valid = count_q != 2'd0;
`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted = state_q == HALTED;
`else
  assign bus.halted = 1'b0;
`endif
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && cp == 2'd2));
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + random fetch stream checked against an in-order PC/memory stream model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_fetch_if #(.ADDR_W(10)) bus ();
  instr_fetch #(.ADDR_W(10), .RESET_PC(10'd0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [31:0] mem [1024];
  always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
  int errors = 0;
  int checks = 0;
  int npop = 0;
  int base;
  logic [9:0] exp_req, exp_pop, hold_pc;
  logic [31:0] hold_instr, s_instr;
  logic hold, s_en, s_valid, s_halted;
  logic [9:0] s_addr, s_pc;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic cyc(input logic rdy, input logic rd, input logic [9:0] rpc);
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    @(negedge clk);
    s_en = bus.imem_en; s_addr = bus.imem_addr; s_valid = bus.instr_valid;
    s_pc = bus.instr_pc; s_instr = bus.instr; s_halted = bus.halted;
    if (hold) begin
      chk("hold_valid", 32'(s_valid), 32'd1);
      chk("hold_pc", 32'(s_pc), 32'(hold_pc));
      chk("hold_instr", s_instr, hold_instr);
    end
    if (s_en) begin
      chk("req_addr", 32'(s_addr), 32'(exp_req));
      exp_req = exp_req + 10'd1;
    end
    if (s_valid && rdy) begin
      chk("pop_pc", 32'(s_pc), 32'(exp_pop));
      chk("pop_instr", s_instr, mem[exp_pop]);
      exp_pop = exp_pop + 10'd1;
      npop++;
    end
    hold = s_valid && !rdy && !rd;
    hold_pc = s_pc;
    hold_instr = s_instr;
    if (rd) begin
      exp_req = rpc;
      exp_pop = rpc;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    rst = 1'b1;
    #1;
    chk("rst_en", 32'(bus.imem_en), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_pc", 32'(bus.instr_pc), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_req = '0;
    exp_pop = '0;
    hold = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = i;
    bus.imem_rdata = '0;
    do_reset();
    // streaming from reset: valid two cycles after the first request, then one per cycle
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("t1_en", 32'(s_en), 32'd1);
      chk("t1_valid", 32'(s_valid), 32'(i >= 2));
    end
    chk("t1_count", 32'(npop), 32'd8);
    // redirect coinciding with a pop
    cyc(1'b1, 1'b1, 10'h040);
    chk("rd_en_n", 32'(s_en), 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("rd_valid_n1", 32'(s_valid), 32'd0);
    chk("rd_en_n1", 32'(s_en), 32'd1);
    chk("rd_addr_n1", 32'(s_addr), 32'h040);
    cyc(1'b1, 1'b0, '0);
    chk("rd_valid_n2", 32'(s_valid), 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("rd_valid_n3", 32'(s_valid), 32'd1);
    chk("rd_pc_n3", 32'(s_pc), 32'h040);
    repeat (3) cyc(1'b1, 1'b0, '0);
    // redirect with a full, stalled buffer, landing on the last word address
    repeat (4) cyc(1'b0, 1'b0, '0);
    chk("full_en", 32'(s_en), 32'd0);
    cyc(1'b0, 1'b1, 10'h3FF);
    chk("rdf_en", 32'(s_en), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, '0);
      if (i == 0) chk("wrap_addr0", 32'(s_addr), 32'h3FF);
      if (i == 1) chk("wrap_addr1", 32'(s_addr), 32'h000);
      if (i == 2) chk("wrap_pc0", 32'(s_pc), 32'h3FF);
      if (i == 3) chk("wrap_pc1", 32'(s_pc), 32'h000);
    end
    // reset mid-stream, then hold ready low: two requests and a held head
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b0, '0);
      chk("stall_en", 32'(s_en), 32'(i < 2));
      chk("stall_valid", 32'(s_valid), 32'(i >= 2));
      if (i >= 2) chk("stall_instr", s_instr, 32'd0);
    end
    base = npop;
    repeat (6) cyc(1'b1, 1'b0, '0);
    chk("stall_resume", 32'(npop - base), 32'd6);
    // random ready and redirects against the stream model
    base = npop;
    for (int i = 0; i < 300; i++)
      cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0), 10'($urandom));
    chk("rand_progress", 32'(npop - base >= 50), 32'd1);
    mem[3] = 32'hFFFF_FFFF;
`ifdef FETCH_HALT_DETECT_EN
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("halt_en", 32'(s_en), 32'(i <= 4));
      chk("halt_halted", 32'(s_halted), 32'(i >= 6));
      if (i >= 6) chk("halt_valid", 32'(s_valid), 32'd0);
    end
    chk("halt_last_pc", 32'(exp_pop), 32'd4);
    cyc(1'b1, 1'b1, 10'h040);
    cyc(1'b1, 1'b0, '0);
    chk("halt_ign_en", 32'(s_en), 32'd0);
    chk("halt_ign_halted", 32'(s_halted), 32'd1);
    do_reset();
    repeat (5) cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 10'h040);
    base = npop;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("unhalt_halted", 32'(s_halted), 32'd0);
      chk("unhalt_en", 32'(s_en), 32'd1);
    end
    chk("unhalt_pops", 32'(npop - base), 32'd4);
`else
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, '0);
      chk("ffff_en", 32'(s_en), 32'd1);
      chk("ffff_halted", 32'(s_halted), 32'd0);
    end
    chk("ffff_pops", 32'(npop >= 6), 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
